// File: rtl/bar_render_pkg.sv
// ============================================================================
// Package : bar_render_pkg
// Brief   : Shared types, widths and default colours for the bar renderer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bar_render_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int COORD_W  = 10;
  localparam int CMP_W    = 11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [23:0] DEF_BAR_RGB  = 24'hFF_8000;
  localparam logic [23:0] DEF_BG_RGB   = 24'h00_0000;
  localparam logic [23:0] DEF_PEAK_RGB = 24'hFF_FFFF;

  function automatic logic [CMP_W-1:0] zext(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_edge_sync.sv
// ============================================================================
// Module : frame_edge_sync
// Brief  : Two-flop synchronizer followed by a registered rising-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic i_in,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_meta  <= i_in;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_pulse <= r_sync & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/bar_renderer.sv
// ============================================================================
// Module : bar_renderer
// Brief  : Per-frame geometry snapshot, 2-stage hit test and RGB output.
//          Define BAR_RENDERER_PEAK_EN to add the decaying peak-hold marker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bar_renderer
  import bar_render_pkg::*;
#(
  parameter logic [23:0] BAR_RGB     = DEF_BAR_RGB,
  parameter logic [23:0] BG_RGB      = DEF_BG_RGB,
  parameter logic [23:0] PEAK_RGB    = DEF_PEAK_RGB,
  parameter int          HOLD_FRAMES = 30
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [COORD_W-1:0] BarX,
  input  logic [COORD_W-1:0] BarY,
  input  logic [COORD_W-1:0] BarW,
  input  logic [COORD_W-1:0] BarH,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               DrawValid,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue,
  output logic               PixValid,
  output logic               FrameLatched
);

  logic               w_pulse;
  logic [COORD_W-1:0] r_sx, r_sy, r_sw, r_sh;
  logic [COORD_W-1:0] w_peak;
  logic [CMP_W-1:0]   w_dx, w_dy, w_sx, w_sy, w_sw, w_sh, w_pk;
  logic               w_in_x, w_in_y, w_hit, w_mark;
  logic               r_valid1, r_hit1, r_mark1;
  logic               r_valid2;
  rgb_t               r_rgb;

  frame_edge_sync u_sync (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_in    (frame_clk),
    .o_pulse (w_pulse)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sx <= '0;
      r_sy <= '0;
      r_sw <= '0;
      r_sh <= '0;
    end else if (w_pulse) begin
      r_sx <= BarX;
      r_sy <= BarY;
      r_sw <= BarW;
      r_sh <= BarH;
    end
  end

`ifdef BAR_RENDERER_PEAK_EN
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);

  logic [COORD_W-1:0] r_peak;
  logic [7:0]         r_hold;

  // Decision uses the incoming BarH, the same value the shadow latches this edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_peak <= '0;
      r_hold <= '0;
    end else if (w_pulse) begin
      if (BarH >= r_peak) begin
        r_peak <= BarH;
        r_hold <= HOLD_INIT;
      end else if (r_hold != 8'd0) begin
        r_hold <= r_hold - 8'd1;
      end else if (r_peak != '0) begin
        r_peak <= r_peak - COORD_W'(1);
      end
    end
  end

  assign w_peak = r_peak;
`else
  assign w_peak = '0;
`endif

  // 11-bit compares so that X+W past the screen edge and H past row 0 never wrap.
  assign w_dx = zext(DrawX);
  assign w_dy = zext(DrawY);
  assign w_sx = zext(r_sx);
  assign w_sy = zext(r_sy);
  assign w_sw = zext(r_sw);
  assign w_sh = zext(r_sh);
  assign w_pk = zext(w_peak);

  assign w_in_x = (w_dx >= w_sx) && (w_dx < (w_sx + w_sw));
  assign w_in_y = (w_dy <= w_sy) && ((w_dy + w_sh) > w_sy);
  assign w_hit  = w_in_x && w_in_y && (r_sw != '0) && (r_sh != '0);
  assign w_mark = w_in_x && (w_pk <= w_sy) && (w_dy == (w_sy - w_pk)) && (w_peak > r_sh);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid1 <= 1'b0;
      r_hit1   <= 1'b0;
      r_mark1  <= 1'b0;
    end else begin
      r_valid1 <= DrawValid;
      r_hit1   <= w_hit;
      r_mark1  <= w_mark;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid2 <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_valid2 <= r_valid1;
      if (!r_valid1) begin
        r_rgb <= '0;
      end else if (r_mark1) begin
        r_rgb <= PEAK_RGB;
      end else if (r_hit1) begin
        r_rgb <= BAR_RGB;
      end else begin
        r_rgb <= BG_RGB;
      end
    end
  end

  assign Red          = r_rgb.r;
  assign Green        = r_rgb.g;
  assign Blue         = r_rgb.b;
  assign PixValid     = r_valid2;
  assign FrameLatched = w_pulse;

endmodule

`default_nettype wire

// File: tb/tb_bar_renderer.sv
// ============================================================================
// Module : tb_bar_renderer
// Brief  : Self-checking bench for bar_renderer against a behavioural model.
//          Honours BAR_RENDERER_PEAK_EN for the peak-marker expectations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bar_renderer;

  localparam logic [23:0] BAR  = 24'hFF_8000;
  localparam logic [23:0] BG   = 24'h00_0000;
  localparam logic [23:0] PEAK = 24'hFF_FFFF;
  localparam int          HOLD = 30;
`ifdef BAR_RENDERER_PEAK_EN
  localparam logic [23:0] MARK_EXP = PEAK;
`else
  localparam logic [23:0] MARK_EXP = BG;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] BarX = '0, BarY = '0, BarW = '0, BarH = '0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       DrawValid = 1'b0;
  logic [7:0] Red, Green, Blue;
  logic       PixValid, FrameLatched;

  int n_checks = 0;
  int n_err    = 0;

  bar_renderer #(
    .BAR_RGB     (BAR),
    .BG_RGB      (BG),
    .PEAK_RGB    (PEAK),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .BarX         (BarX),
    .BarY         (BarY),
    .BarW         (BarW),
    .BarH         (BarH),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .DrawValid    (DrawValid),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .PixValid     (PixValid),
    .FrameLatched (FrameLatched)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: shadow box, peak state, frame_clk sample history, 2-deep output queue.
  int         m_sx = 0, m_sy = 0, m_sw = 0, m_sh = 0, m_peak = 0, m_hold = 0;
  bit [3:0]   m_hist = '0;
  bit         m_pulse = 1'b0;
  logic [24:0] m_exp1 = '0, m_exp2 = '0;

  function automatic logic [24:0] model_px(input int x, input int y, input bit v);
    bit inx, iny, hit, mk;
    if (!v) return 25'd0;
    inx = (x >= m_sx) && (x < m_sx + m_sw);
    iny = (y <= m_sy) && (y > m_sy - m_sh);
    hit = inx && iny && (m_sw != 0) && (m_sh != 0);
    mk  = inx && (m_peak <= m_sy) && (y == m_sy - m_peak) && (m_peak > m_sh);
    return {1'b1, mk ? PEAK : (hit ? BAR : BG)};
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_sx = 0; m_sy = 0; m_sw = 0; m_sh = 0; m_peak = 0; m_hold = 0;
      m_hist = '0; m_pulse = 1'b0; m_exp1 = '0; m_exp2 = '0;
    end else begin
      m_exp2 = m_exp1;
      m_exp1 = model_px(int'(DrawX), int'(DrawY), DrawValid);
      if (m_pulse) begin
        m_sx = int'(BarX); m_sy = int'(BarY); m_sw = int'(BarW); m_sh = int'(BarH);
`ifdef BAR_RENDERER_PEAK_EN
        if (m_sh >= m_peak) begin
          m_peak = m_sh; m_hold = HOLD;
        end else if (m_hold > 0) m_hold = m_hold - 1;
        else if (m_peak > 0) m_peak = m_peak - 1;
`endif
      end
      m_hist  = {m_hist[2:0], frame_clk};
      m_pulse = m_hist[2] && !m_hist[3];
    end
  end

  always @(negedge Clk) begin
    chk("rgb", {8'd0, Red, Green, Blue}, {8'd0, m_exp2[23:0]});
    chk("pixvalid", {31'd0, PixValid}, {31'd0, m_exp2[24]});
    chk("frame_latched", {31'd0, FrameLatched}, {31'd0, m_pulse});
  end

  task automatic px_lit(input string nm, input int x, input int y, input logic [23:0] exp);
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y); DrawValid = 1'b1;
    repeat (2) @(negedge Clk);
    chk(nm, {8'd0, Red, Green, Blue}, {8'd0, exp});
  endtask

  task automatic do_frame(input int x, input int y, input int w, input int h);
    @(negedge Clk);
    BarX = 10'(x); BarY = 10'(y); BarW = 10'(w); BarH = 10'(h); frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  function automatic int clamp10(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  int lat, pulses, gx, gy, gw, gh;

  initial begin
    DrawValid = 1'b1; DrawX = 10'd320; DrawY = 10'd240;
    repeat (4) @(negedge Clk);
    chk("reset_pixvalid", {31'd0, PixValid}, 32'd0);
    chk("reset_rgb", {8'd0, Red, Green, Blue}, 32'd0);
    Reset = 1'b0;
    px_lit("empty_shadow", 320, 240, BG);

    // Frame latency and single pulse for a held level.
    @(negedge Clk);
    BarX = 10'd320; BarY = 10'd240; BarW = 10'd4; BarH = 10'd50; frame_clk = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge Clk);
      if (FrameLatched) lat = i;
    end
    chk("frame_latency", lat, 3);
    pulses = 0;
    repeat (8) begin
      @(negedge Clk);
      if (FrameLatched) pulses++;
    end
    chk("held_level_single_pulse", pulses, 0);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);

    px_lit("bar_bottom_left", 320, 240, BAR);
    px_lit("bar_top_right", 323, 191, BAR);
    px_lit("right_of_bar", 324, 240, BG);
    px_lit("above_bar", 320, 190, BG);
    px_lit("below_bar", 320, 241, BG);

    do_frame(320, 240, 4, 0);
    px_lit("zero_height", 320, 240, BG);
    do_frame(320, 240, 0, 50);
    px_lit("zero_width", 320, 240, BG);

    do_frame(638, 4, 4, 5);
    px_lit("clip_x_639", 639, 4, BAR);
    px_lit("clip_x_row0", 638, 0, BAR);
    px_lit("clip_x_col0", 0, 4, BG);
    px_lit("clip_x_col1023", 1023, 4, BG);
    px_lit("clip_x_row5", 639, 5, BG);
    do_frame(10, 2, 4, 10);
    px_lit("clip_y_row0", 10, 0, BAR);
    px_lit("clip_y_row2", 13, 2, BAR);
    px_lit("clip_y_row479", 10, 479, BG);
    px_lit("clip_y_row1023", 10, 1023, BG);

    // Geometry swap while the scan streams between the old and new boxes.
    do_frame(100, 100, 10, 10);
    @(negedge Clk);
    BarX = 10'd200; BarY = 10'd200; frame_clk = 1'b1;
    for (int i = 0; i < 12; i++) begin
      DrawX = (i % 2 == 0) ? 10'd105 : 10'd205;
      DrawY = (i % 2 == 0) ? 10'd95  : 10'd195;
      @(negedge Clk);
    end
    frame_clk = 1'b0;
    px_lit("new_box_live", 205, 195, BAR);
    px_lit("old_box_gone", 105, 95, BG);

    // Asynchronous reset while the bar is being drawn.
    do_frame(320, 240, 4, 50);
    px_lit("pre_reset_bar", 320, 240, BAR);
    @(posedge Clk); #2;
    Reset = 1'b1;
    #1;
    chk("reset_async_rgb", {8'd0, Red, Green, Blue}, 32'd0);
    chk("reset_async_valid", {31'd0, PixValid}, 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    px_lit("post_reset_empty", 320, 240, BG);

    // Peak hold: 50 then 30 frames of 40 keep the peak, the next frame decays it.
    do_frame(320, 240, 4, 50);
    for (int f = 0; f < 30; f++) do_frame(320, 240, 4, 40);
    px_lit("peak_hold_row190", 320, 190, MARK_EXP);
    px_lit("peak_hold_row191", 320, 191, BG);
    do_frame(320, 240, 4, 40);
    px_lit("peak_decay_row191", 320, 191, MARK_EXP);
    px_lit("peak_decay_row190", 320, 190, BG);
    px_lit("peak_bar_top", 320, 201, BAR);

    // Randomized streams with frame edges and geometry changes landing anywhere.
    for (int f = 0; f < 30; f++) begin
      gx = $urandom_range(0, 700); gy = $urandom_range(0, 520);
      gw = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 80);
      gh = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
      @(negedge Clk);
      BarX = 10'(gx); BarY = 10'(gy); BarW = 10'(gw); BarH = 10'(gh);
      for (int p = 0; p < 80; p++) begin
        @(negedge Clk);
        if ($urandom_range(0, 3) == 0) begin
          DrawX = 10'($urandom_range(0, 1023));
          DrawY = 10'($urandom_range(0, 1023));
        end else begin
          DrawX = 10'(clamp10(gx - 5 + int'($urandom_range(0, gw + 10))));
          DrawY = 10'(clamp10(gy - gh - 8 + int'($urandom_range(0, gh + 16))));
        end
        DrawValid = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 11) == 0) frame_clk = ~frame_clk;
        if ($urandom_range(0, 39) == 0) BarH = 10'($urandom_range(0, 300));
      end
    end
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
